exe_result_fwd: RTL

- EXE→MEM→WB result path for the 5-stage MIPS pipeline.
- Registers the EXE stage's ALU result, flags and control into MEM, then into WB.
- Drives the forwarded rd1/rd2 values back into the EXE operand inputs for the next instruction.
- Detects load-use hazards and requests a one-cycle stall.

---
 rtl/exe_result_fwd_if.sv | 68 ++++++
 rtl/exe_result_fwd.sv | 135 +++++++++++++
 2 files changed

// File: rtl/exe_result_fwd_if.sv
// exe_result_fwd_if: bundle of EXE inputs, operand-forwarding signals and
// MEM/WB outputs for the EXE->MEM->WB result path.
// The master side drives the EXE/ID inputs, and the slave side is the
// pipeline block. The ex_ovf_chk/ovf_trap pair exists only when
// EXE_OVF_TRAP_EN is defined.
interface exe_result_fwd_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;
    logic          ex_valid;
    logic          ex_wreg;
    logic          ex_m2reg;
    logic          ex_wmem;
    logic [RW-1:0] ex_rn;
    logic [DW-1:0] ex_alud;
    logic [DW-1:0] ex_st_data;
    logic [3:0]    ex_flags;
    logic [DW-1:0] mem_rdata;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] fwd_rd1;
    logic [DW-1:0] fwd_rd2;
    logic          load_use_stall;
    logic          mem_valid;
    logic          mem_wreg;
    logic          mem_m2reg;
    logic          mem_wmem;
    logic [RW-1:0] mem_rn;
    logic [DW-1:0] mem_alud;
    logic [DW-1:0] mem_st_data;
    logic          wb_wreg;
    logic [RW-1:0] wb_rn;
    logic [DW-1:0] wb_data;
`ifdef EXE_OVF_TRAP_EN
    logic          ex_ovf_chk;
    logic          ovf_trap;
`endif

    modport master (
        output stall, flush, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_rn,
               ex_alud, ex_st_data, ex_flags, mem_rdata,
               id_rs, id_rt, id_rd1, id_rd2,
`ifdef EXE_OVF_TRAP_EN
        output ex_ovf_chk,
        input  ovf_trap,
`endif
        input  fwd_rd1, fwd_rd2, load_use_stall,
               mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_rn,
               mem_alud, mem_st_data, wb_wreg, wb_rn, wb_data
    );

    modport slave (
        input  stall, flush, ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_rn,
               ex_alud, ex_st_data, ex_flags, mem_rdata,
               id_rs, id_rt, id_rd1, id_rd2,
`ifdef EXE_OVF_TRAP_EN
        input  ex_ovf_chk,
        output ovf_trap,
`endif
        output fwd_rd1, fwd_rd2, load_use_stall,
               mem_valid, mem_wreg, mem_m2reg, mem_wmem, mem_rn,
               mem_alud, mem_st_data, wb_wreg, wb_rn, wb_data
    );
endinterface

// File: rtl/exe_result_fwd.sv
// exe_result_fwd: EXE->MEM->WB result registers for a 5-stage MIPS pipeline.
// The block has combinational operand forwarding from MEM/WB back to EXE and
// load-use hazard detection.
// Optional feature macro EXE_OVF_TRAP_EN: latches ALU flags into MEM and
// raises ovf_trap for overflow-checked ops. A trapped op never writes back
// and is never forwarded.
module exe_result_fwd #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic               clk,
    input logic               rst,
    exe_result_fwd_if.slave   bus
);
    // MEM stage state
    logic          mem_valid_reg;
    logic          mem_wreg_reg;
    logic          mem_m2reg_reg;
    logic          mem_wmem_reg;
    logic [RW-1:0] mem_rn_reg;
    logic [DW-1:0] mem_alud_reg;
    logic [DW-1:0] mem_st_data_reg;

    // WB stage state
    logic          wb_wreg_reg;
    logic [RW-1:0] wb_rn_reg;
    logic [DW-1:0] wb_data_reg;

    // An invalid or flushed EXE slot enters MEM as a bubble
    logic take;
    assign take = bus.ex_valid & ~bus.flush;

    // Overflow trap from the MEM-stage instruction (constant 0 when disabled)
    logic trap;

`ifdef EXE_OVF_TRAP_EN
    logic [3:0] mem_flags_reg;
    logic       mem_ovf_chk_reg;

    // Latch ALU flags and the overflow-check qualifier alongside MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_flags_reg   <= '0;
            mem_ovf_chk_reg <= 1'b0;
        end else if (!bus.stall) begin
            mem_flags_reg   <= bus.ex_flags;
            mem_ovf_chk_reg <= take & bus.ex_ovf_chk;
        end
    end

    // ex_flags = {zero, carry, negative, overflow}
    assign trap         = mem_valid_reg & mem_ovf_chk_reg & mem_flags_reg[0];
    assign bus.ovf_trap = trap;
`else
    assign trap = 1'b0;
`endif

    // EXE -> MEM register; stall freezes it and takes priority over flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_reg   <= 1'b0;
            mem_wreg_reg    <= 1'b0;
            mem_m2reg_reg   <= 1'b0;
            mem_wmem_reg    <= 1'b0;
            mem_rn_reg      <= '0;
            mem_alud_reg    <= '0;
            mem_st_data_reg <= '0;
        end else if (!bus.stall) begin
            mem_valid_reg   <= take;
            mem_wreg_reg    <= take & bus.ex_wreg;
            mem_m2reg_reg   <= take & bus.ex_m2reg;
            mem_wmem_reg    <= take & bus.ex_wmem;
            mem_rn_reg      <= bus.ex_rn;
            mem_alud_reg    <= bus.ex_alud;
            mem_st_data_reg <= bus.ex_st_data;
        end
    end

    // MEM -> WB register; loads take memory data, everything else the ALU result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wreg_reg <= 1'b0;
            wb_rn_reg   <= '0;
            wb_data_reg <= '0;
        end else if (!bus.stall) begin
            wb_wreg_reg <= mem_valid_reg & mem_wreg_reg & ~trap;
            wb_rn_reg   <= mem_rn_reg;
            wb_data_reg <= mem_m2reg_reg ? bus.mem_rdata : mem_alud_reg;
        end
    end

    // MEM may forward only finished ALU results; load data is not ready yet
    logic mem_fwd_ok;
    assign mem_fwd_ok = mem_valid_reg & mem_wreg_reg & ~mem_m2reg_reg & ~trap;

    logic [RW-1:0] src_rn [2];
    logic [DW-1:0] src_rf [2];
    assign src_rn[0] = bus.id_rs;
    assign src_rn[1] = bus.id_rt;
    assign src_rf[0] = bus.id_rd1;
    assign src_rf[1] = bus.id_rd2;

    // One forwarding mux per operand: MEM beats WB, WB beats the register file
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [DW-1:0] val;

        // Select the youngest in-flight producer of this source register
        always_comb begin
            val = src_rf[gi];
            if (mem_fwd_ok && (mem_rn_reg == src_rn[gi]) && (src_rn[gi] != '0))
                val = mem_alud_reg;
            else if (wb_wreg_reg && (wb_rn_reg == src_rn[gi]) && (src_rn[gi] != '0))
                val = wb_data_reg;
        end
    end

    assign bus.fwd_rd1 = g_fwd[0].val;
    assign bus.fwd_rd2 = g_fwd[1].val;

    // A load in MEM whose target is read in ID needs one bubble; WB covers it next
    assign bus.load_use_stall = mem_valid_reg & mem_m2reg_reg & mem_wreg_reg &
                                (mem_rn_reg != '0) &
                                ((mem_rn_reg == bus.id_rs) | (mem_rn_reg == bus.id_rt));

    assign bus.mem_valid   = mem_valid_reg;
    assign bus.mem_wreg    = mem_wreg_reg;
    assign bus.mem_m2reg   = mem_m2reg_reg;
    assign bus.mem_wmem    = mem_wmem_reg;
    assign bus.mem_rn      = mem_rn_reg;
    assign bus.mem_alud    = mem_alud_reg;
    assign bus.mem_st_data = mem_st_data_reg;
    assign bus.wb_wreg     = wb_wreg_reg;
    assign bus.wb_rn       = wb_rn_reg;
    assign bus.wb_data     = wb_data_reg;
endmodule
